// File: rtl/sfu_pkg.sv
// sfu_pkg: shared SFU opcodes, default fixed-point formats and poly-eval FSM states
package sfu_pkg;
  localparam logic [3:0] RCP = 4'd0, SQRT = 4'd1, RSQRT = 4'd2, POW2 = 4'd3, LOG2 = 4'd4,
                         SIN = 4'd5, FMA = 4'd6, TANH = 4'd7, SIGMOID = 4'd8;
  localparam int DEF_Y_WL = 25, DEF_Y_FL = 23;
  localparam int DEF_COEF_WL = 29, DEF_COEF_FL = 26;
  localparam int DEF_RES_WL = 50, DEF_RES_FL = 46;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
endpackage

// File: rtl/sfu_poly_mac.sv
// sfu_poly_mac: one Horner/FMA step, acc*y >>> Y_FL plus an aligned addend, saturated to RES_WL
module sfu_poly_mac #(
  parameter int Y_WL = 25,
  parameter int Y_FL = 23,
  parameter int RES_WL = 50
) (
  input  logic signed [RES_WL-1:0] acc,
  input  logic signed [Y_WL-1:0]   y,
  input  logic signed [RES_WL-1:0] addend,
  input  logic                     fma,
  input  logic signed [8:0]        exp_diff,
  output logic signed [RES_WL-1:0] acc_next,
  output logic                     ovf
);
  localparam int SW = RES_WL + 2;
  logic signed [RES_WL+Y_WL-1:0] prod;
  logic signed [SW-1:0] p, a, sum;
  logic signed [9:0] ed;
  logic [9:0] sh;
  always_comb begin
    prod = acc * y;
    p = SW'(prod >>> Y_FL);
    a = SW'(addend);
    ed = 10'(exp_diff);
    sh = exp_diff[8] ? 10'(-ed) : 10'(ed);
    sum = !fma ? p + a : exp_diff[8] ? a + (p >>> sh) : (a >>> sh) + p;
    ovf = sum[SW-1:RES_WL-1] != '0 && sum[SW-1:RES_WL-1] != '1;
    acc_next = ovf ? {sum[SW-1], {(RES_WL-1){~sum[SW-1]}}} : sum[RES_WL-1:0];
  end
endmodule

// File: rtl/sfu_poly_eval.sv
// sfu_poly_eval: iterative Horner polynomial / FMA evaluator sharing one multiply-add step
module sfu_poly_eval
  import sfu_pkg::*;
#(
  parameter int MAX_ORDER = 2,
  parameter int Y_WL = DEF_Y_WL,
  parameter int Y_FL = DEF_Y_FL,
  parameter int COEF_WL = DEF_COEF_WL,
  parameter int COEF_FL = DEF_COEF_FL,
  parameter int RES_WL = DEF_RES_WL,
  parameter int RES_FL = DEF_RES_FL
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [3:0]                           in_op,
  input  logic [$clog2(MAX_ORDER+1)-1:0]       in_ord,
  input  logic                                 in_skip,
  input  logic signed [Y_WL-1:0]               in_y,
  input  logic [(MAX_ORDER+1)*COEF_WL-1:0]     in_coef,
  input  logic signed [8:0]                    in_exp_diff,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [RES_WL-1:0]             out_result,
  output logic                                 out_ovf
);
  localparam int OW = $clog2(MAX_ORDER + 1);
  localparam int SH = RES_FL - COEF_FL;
  state_t state, state_nx;
  logic [MAX_ORDER:0][COEF_WL-1:0] ci, c_r;
  logic signed [Y_WL-1:0] y_r;
  logic signed [8:0] ed_r;
  logic fma_r, fma_in, go, ovf, mac_ovf;
  logic [OW-1:0] cnt, n;
  logic signed [RES_WL-1:0] acc, addend, mac_res;

  function automatic logic signed [RES_WL-1:0] align(input logic [COEF_WL-1:0] c);
    return RES_WL'($signed(c)) <<< SH;
  endfunction

  assign ci = in_coef;
  assign fma_in = in_op == FMA;
  // FMA always runs exactly one step using c1*y + c0
  assign n = fma_in ? OW'(1) : (in_ord > OW'(MAX_ORDER) ? OW'(MAX_ORDER) : in_ord);
  assign in_ready = state == IDLE;
  assign go = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign out_result = acc;
  assign out_ovf = ovf;
  assign addend = align(c_r[cnt - 1'b1]);

  sfu_poly_mac #(.Y_WL(Y_WL), .Y_FL(Y_FL), .RES_WL(RES_WL)) u_mac (
    .acc(acc),
    .y(y_r),
    .addend(addend),
    .fma(fma_r),
    .exp_diff(ed_r),
    .acc_next(mac_res),
    .ovf(mac_ovf)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go) state_nx = (in_skip || n == '0) ? DONE : EVAL;
      EVAL: if (cnt == OW'(1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      y_r <= '0;
      c_r <= '0;
      ed_r <= '0;
      fma_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        y_r <= in_y;
        c_r <= in_coef;
        ed_r <= in_exp_diff;
        fma_r <= fma_in;
        cnt <= n;
        ovf <= 1'b0;
        acc <= in_skip ? (fma_in ? align(ci[0]) : '0) : align(ci[n]);
      end else if (state == EVAL) begin
        acc <= mac_res;
        ovf <= ovf | mac_ovf;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sfu_poly_eval.sv
// tb_sfu_poly_eval: scoreboard bench for sfu_poly_eval with hand-computed directed vectors
module tb_sfu_poly_eval;
  import sfu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_skip = 1'b0, out_valid, out_ready = 1'b1, out_ovf;
  logic [3:0] in_op = '0;
  logic [1:0] in_ord = '0;
  logic signed [24:0] in_y = '0;
  logic [86:0] in_coef = '0;
  logic signed [8:0] in_exp_diff = '0;
  logic signed [49:0] out_result;
  int cyc = 0, checks = 0, passes = 0;
  bit seen = 0;

  typedef struct {
    logic signed [63:0] res;
    logic ovf;
    int lat;
    int acc_cyc;
  } exp_t;
  exp_t q[$];

  localparam logic signed [28:0] C1P0 = 29'sd67108864, C0P5 = 29'sd33554432, C0P25 = 29'sd16777216;
  localparam logic signed [28:0] C3P9 = 29'sd261724570, CM4 = -29'sd268435456;
  localparam logic signed [24:0] Y0P5 = 25'sd4194304, Y1P99 = 25'sd16693330;

  sfu_poly_eval dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_ord(in_ord), .in_skip(in_skip), .in_y(in_y), .in_coef(in_coef),
    .in_exp_diff(in_exp_diff), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output got=%0d expected=none", out_result);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
        end
        check("result", 64'(out_result), q[0].res);
        check("ovf", 64'(out_ovf), 64'(q[0].ovf));
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic set_in(input logic [3:0] op, input logic [1:0] ord, input logic skip,
                        input logic signed [24:0] y, input logic signed [28:0] c0,
                        input logic signed [28:0] c1, input logic signed [28:0] c2,
                        input logic signed [8:0] ed);
    in_op = op; in_ord = ord; in_skip = skip; in_y = y;
    in_coef = {c2, c1, c0}; in_exp_diff = ed;
  endtask

  // called and returns on a negedge; expectation is pushed in the accept cycle
  task automatic send(input logic [3:0] op, input logic [1:0] ord, input logic skip,
                      input logic signed [24:0] y, input logic signed [28:0] c0,
                      input logic signed [28:0] c1, input logic signed [28:0] c2,
                      input logic signed [8:0] ed, input logic signed [63:0] res,
                      input logic ovf, input int lat);
    set_in(op, ord, skip, y, c0, c1, c2, ed);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      q.push_back('{res: res, ovf: ovf, lat: lat, acc_cyc: cyc});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(POW2, 2'd2, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd21 <<< 42, 0, 3);
    send(FMA, 2'd2, 0, Y0P5, C1P0, C1P0, 29'sd0, 9'sd1, 64'sd1 <<< 46, 0, 2);
    send(FMA, 2'd0, 0, Y0P5, C1P0, C1P0, 29'sd0, -9'sd2, 64'sd9 <<< 43, 0, 2);
    send(FMA, 2'd2, 1, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd1 <<< 46, 0, 1);
    send(SIN, 2'd2, 1, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd0, 0, 1);
    send(TANH, 2'd2, 0, Y1P99, C3P9, C3P9, C3P9, 9'sd0, (64'sd1 <<< 49) - 1, 1, 3);
    send(LOG2, 2'd3, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd21 <<< 42, 0, 3);
    send(RCP, 2'd0, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd1 <<< 46, 0, 1);
    send(SIN, 2'd1, 0, -Y0P5, 29'sd0, C1P0, C3P9, 9'sd0, -(64'sd1 <<< 45), 0, 2);
    send(SIN, 2'd1, 0, -25'sd1, 29'sd0, 29'sd1, 29'sd0, 9'sd0, -64'sd1, 0, 2);
    send(FMA, 2'd1, 0, Y0P5, C1P0, C1P0, 29'sd0, 9'sd100, 64'sd1 <<< 45, 0, 2);
    send(FMA, 2'd1, 0, Y0P5, C1P0, C1P0, 29'sd0, -9'sd256, 64'sd1 <<< 46, 0, 2);
    send(SQRT, 2'd1, 0, Y1P99, CM4, CM4, 29'sd0, 9'sd0, -(64'sd1 <<< 49), 1, 2);
    send(SQRT, 2'd1, 0, Y0P5, C1P0, C1P0, 29'sd0, 9'sd0, 64'sd3 <<< 45, 0, 2);
    drain();
    // backpressure: a second request is held on in_valid while the first output stalls
    out_ready = 1'b0;
    send(POW2, 2'd2, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd21 <<< 42, 0, 3);
    set_in(FMA, 2'd0, 1, Y0P5, C0P5, C1P0, C1P0, 9'sd0);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_reaccept_ready", 64'(in_ready), 64'd1);
    send(FMA, 2'd0, 1, Y0P5, C0P5, C1P0, C1P0, 9'sd0, 64'sd1 <<< 45, 0, 1);
    drain();
    // reset during EVAL aborts the request
    set_in(POW2, 2'd2, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("eval_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_result", 64'(out_result), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_abort_valid", 64'(out_valid), 64'd0);
    end
    check("post_abort_ready", 64'(in_ready), 64'd1);
    send(RCP, 2'd0, 0, Y0P5, C1P0, C0P5, C0P25, 9'sd0, 64'sd1 <<< 46, 0, 1);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sfu_poly_eval.md
# sfu_poly_eval

Parametrised, iterative polynomial evaluator for the SFU datapath: the successor to the fixed order-1/order-2 combinational approximation stage. It evaluates c0 + c1·y + … + cN·y^N by Horner's scheme on one shared multiplier, and selects the order per request. It also supports the FMA alignment mode, skip, and saturating output with an overflow flag. It sits between the SFU coefficient-lookup stage and the output normaliser, with valid/ready handshakes on both sides.

## Interface
Parameters:
- MAX_ORDER, 2: highest supported polynomial order (≥1)
- Y_WL / Y_FL, 25 / 23: signed fixed-point width and fraction of y
- COEF_WL / COEF_FL, 29 / 26: signed fixed-point width and fraction of every coefficient
- RES_WL / RES_FL, 50 / 46: signed width and fraction of the result and accumulator

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- in_op  in  4  SFU opcode; only FMA (4'b0110) changes behaviour
- in_ord  in  $clog2(MAX_ORDER+1)  requested order; values > MAX_ORDER clamp to MAX_ORDER
- in_skip  in  1  bypass evaluation
- in_y  in  Y_WL  signed reduced argument
- in_coef  in  (MAX_ORDER+1)×COEF_WL  packed coefficients, index k = ck
- in_exp_diff  in  9  signed FMA alignment shift
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  RES_WL  signed result
- out_ovf  out  1  saturation occurred during this request

## Operation
- FSM states: IDLE, EVAL, DONE.
- On accept (in_valid & in_ready), the block registers y, the coefficients, op, exp_diff and the clamped order n. It loads acc = align(c_n) and clears ovf.
  - align(c) = sign-extend c, then shift left by RES_FL−COEF_FL.
- Polynomial mode (non-FMA, no skip):
  - If n=0: go to DONE.
  - Otherwise go to EVAL with a step counter of n.
  - Each EVAL cycle: p = (acc·y) >>> Y_FL (arithmetic shift, floor), then acc = sat(p + align(c_{k−1})). k counts down from n to 1.
  - Leave EVAL when the counter reaches 0.
- Intermediate sums use RES_WL+2 bits. sat() clamps to [−2^(RES_WL−1), 2^(RES_WL−1)−1] and sets ovf sticky.
- FMA mode (in_op==FMA, no skip): n is forced to 1 and there is exactly one EVAL cycle.
  - Compute p = (align(c1)·y) >>> Y_FL.
  - If exp_diff ≥ 0: result = sat((align(c0) >>> exp_diff) + p).
  - Otherwise: result = sat(align(c0) + (p >>> −exp_diff)).
  - Shift amounts ≥ RES_WL produce pure sign fill.
- Skip: go directly to DONE. Result is align(c0) for FMA and 0 otherwise; ovf = 0.
- DONE: out_valid=1, with out_result=acc and out_ovf=ovf held stable until out_ready. On that handshake, go to IDLE.
- in_ready=0 in EVAL and DONE. in_valid in those states is ignored and not buffered.

## Timing
- Reset values: state IDLE; out_valid 0, out_result 0, out_ovf 0; in_ready 1.
- Accept at edge T. out_valid rises after edge T+1+s, where s = EVAL steps:
  - s = n for polynomial mode, 1 for FMA, 0 for skip or n=0.
- Output handshake at edge D → in_ready high after D. There is no same-cycle re-accept, so the minimum initiation interval is s+2 cycles.
- Reset asserted mid-EVAL or mid-DONE aborts the request at once. No output is produced and the block returns to reset values.
- out_ready asserted while out_valid=0 has no effect.

## Structure
- Shared package sfu_pkg holds:
  - opcode constants: RCP, SQRT, RSQRT, POW2, LOG2, SIN, FMA, TANH, SIGMOID;
  - default fixed-point format localparams;
  - the FSM state enum.
- One sub-module, sfu_poly_mac: combinational multiply–shift–add–saturate step returning {acc_next, ovf}. It is instantiated once and shared by the polynomial and FMA paths.

## Test plan
- Polynomial, ord=2: y=0.5, c0=1.0, c1=0.5, c2=0.25 → out_result = 1.3125·2^46, out_ovf=0, out_valid 3 cycles after accept.
- FMA: c0=1.0, c1=1.0, y=0.5.
  - exp_diff=+1 → result 1.0·2^46.
  - exp_diff=−2 → result 1.125·2^46.
  - Both with 2-cycle latency.
- Skip: FMA with c0=1.0 → 1.0·2^46; SIN with c0=1.0 → 0; both after 1 cycle.
- Saturation: ord=2, c0=c1=c2=3.9, y=1.99 → out_result = 2^49−1, out_ovf=1.
- Backpressure: out_ready low for 5 cycles → out_result stable, in_ready=0, a concurrent in_valid is dropped. Next accept occurs the cycle after the handshake.
- Edge and reset cases:
  - in_ord=3 with MAX_ORDER=2 → behaves as ord=2.
  - ord=0 → result align(c0) after 1 cycle.
  - rst_n low during EVAL → out_valid never rises; in_ready=1 after release.
